// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder with a 4-entry output FIFO and a consumed-word counter.
// Optional macro ENC_IMM_CHECK_EN tags words whose immediate does not fit its format.
module instr_encoder (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op_class,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic signed [12:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_err,
    output logic [15:0]        instr_count
);
    localparam int DEPTH = 4;

    logic [31:0] mem [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  occ;
    logic [2:0]  occ_next;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

    function automatic logic [31:0] encode(
        input logic [1:0]         op,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic [4:0]         d,
        input logic [4:0]         s1,
        input logic [4:0]         s2,
        input logic signed [12:0] im
    );
        logic [31:0] w;
        case (op)
            2'b00:   w = {f7, s2, s1, f3, d, 7'b0110011};
            2'b01:   w = {im[11:0], s1, f3, d, 7'b0000011};
            2'b10:   w = {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
            default: w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
        endcase
        return w;
    endfunction

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (occ != 3'd0);
    assign enc_word  = encode(op_class, funct3, funct7, rd, rs1, rs2, imm);
    // Gate the head with out_valid so an empty or resetting FIFO shows zero.
    assign out_instr = out_valid ? mem[rd_ptr] : 32'd0;

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 3'd1;
            2'b01:   occ_next = occ - 3'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            occ         <= 3'd0;
            in_ready    <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 2'd1;
                instr_count <= instr_count + 16'd1;
            end
            occ      <= occ_next;
            in_ready <= (occ_next < 3'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

`ifdef ENC_IMM_CHECK_EN
    logic [DEPTH-1:0] err_mem;
    logic             enc_err;

    // Load/store need imm to fit 12 signed bits; branch targets must be even.
    function automatic logic imm_err(input logic [1:0] op, input logic signed [12:0] im);
        case (op)
            2'b01, 2'b10: return (im[12] != im[11]);
            2'b11:        return im[0];
            default:      return 1'b0;
        endcase
    endfunction

    assign enc_err = imm_err(op_class, imm);
    assign out_err = out_valid ? err_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) err_mem[wr_ptr] <= enc_err;
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes modelled words, negedge monitor pops and compares.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_class;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] instr_count;

    int checks = 0;
    int failures = 0;
    logic [32:0] sb_q[$];
    logic [15:0] exp_count = 16'd0;
    int          ready_mode = 0;
    logic        held = 1'b0;
    logic [32:0] held_val;
    logic        fifth_done;

    instr_encoder dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference encoding from the field placement rules using plain integer arithmetic.
    function automatic logic [31:0] model_word(input int op, input int f3, input int f7,
                                               input int d, input int s1, input int s2, input int u);
        longint unsigned w;
        case (op)
            0: w = f7 * 2**25 + s2 * 2**20 + s1 * 2**15 + f3 * 2**12 + d * 2**7 + 51;
            1: w = (u % 4096) * 2**20 + s1 * 2**15 + f3 * 2**12 + d * 2**7 + 3;
            2: w = ((u % 4096) / 32) * 2**25 + s2 * 2**20 + s1 * 2**15 + f3 * 2**12
                   + (u % 32) * 2**7 + 35;
            default: w = ((u / 4096) % 2) * 64'd2147483648 + ((u / 32) % 64) * 2**25
                   + s2 * 2**20 + s1 * 2**15 + f3 * 2**12 + ((u / 2) % 16) * 2**8
                   + ((u / 2048) % 2) * 2**7 + 99;
        endcase
        return w[31:0];
    endfunction

    function automatic logic model_err(input int op, input logic [12:0] im);
        int s;
        s = $signed(im);
`ifdef ENC_IMM_CHECK_EN
        if (op == 1 || op == 2) return (s < -2048 || s > 2047);
        if (op == 3) return (s % 2 != 0);
`endif
        return 1'b0;
    endfunction

    // Must be called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int op, input int f3, input int f7, input int d,
                        input int s1, input int s2, input logic [12:0] im);
        int n = 0;
        op_class = op[1:0]; funct3 = f3[2:0]; funct7 = f7[6:0];
        rd = d[4:0]; rs1 = s1[4:0]; rs2 = s2[4:0]; imm = im;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back({model_err(op, im), model_word(op, f3, f7, d, s1, s2, int'(im))});
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", {31'd0, out_valid}, 32'd0);
        chk("drain_queue", sb_q.size(), 32'd0);
    endtask

    // Monitor: pops happen at the next posedge when out_valid && out_ready here.
    always @(negedge clk) begin
        if (!reset_n) begin
            out_ready = 1'b0;
        end else begin
            chk("instr_count", {16'd0, instr_count}, {16'd0, exp_count});
            if (held) chk("hold_stable", out_instr, held_val[31:0]);
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            held = 1'b0;
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", out_instr, 32'd0);
                end else if (out_ready) begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("word", out_instr, e[31:0]);
                    chk("err", {31'd0, out_err}, {31'd0, e[32]});
                    exp_count = exp_count + 16'd1;
                end else begin
                    held = 1'b1;
                    held_val = {out_err, out_instr};
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; op_class = 0; funct3 = 0; funct7 = 0;
        rd = 0; rs1 = 0; rs2 = 0; imm = 0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // R-type, one-cycle latency then counted pop
        ready_mode = 1;
        @(negedge clk);
        send(0, 0, 0, 3, 1, 2, 13'd0);
        chk("rtype_valid", {31'd0, out_valid}, 32'd1);
        chk("rtype_word", out_instr, 32'h002081B3);
        @(negedge clk);
        chk("rtype_count", {16'd0, instr_count}, 32'd1);

        send(1, 2, 0, 5, 2, 0, 13'd8);
        chk("load_word", out_instr, 32'h00812283);
        send(2, 2, 0, 0, 2, 5, 13'd12);
        chk("store_word", out_instr, 32'h00512623);
        send(3, 0, 0, 0, 1, 2, 13'h1FFC);
        chk("branch_word", out_instr, 32'hFE208EE3);
        chk("branch_err", {31'd0, out_err}, 32'd0);
        drain();

        // Immediate range checks, observed while the word is held
        ready_mode = 0;
        @(negedge clk);
        send(1, 0, 0, 1, 1, 0, 13'd4095);
`ifdef ENC_IMM_CHECK_EN
        chk("load_imm_err", {31'd0, out_err}, 32'd1);
`else
        chk("load_imm_err", {31'd0, out_err}, 32'd0);
`endif
        ready_mode = 1;
        drain();
        ready_mode = 0;
        @(negedge clk);
        send(3, 0, 0, 0, 1, 2, 13'd3);
`ifdef ENC_IMM_CHECK_EN
        chk("branch_imm_err", {31'd0, out_err}, 32'd1);
`else
        chk("branch_imm_err", {31'd0, out_err}, 32'd0);
`endif
        ready_mode = 1;
        drain();

        // Fill with out_ready=0, fifth bundle must wait for a pop
        ready_mode = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(0, i, i, i + 1, i + 2, i + 3, 13'd0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        fifth_done = 1'b0;
        fork
            begin
                send(1, 7, 0, 9, 10, 0, 13'd100);
                fifth_done = 1'b1;
            end
        join_none
        repeat (3) @(negedge clk);
        chk("fifth_held", {31'd0, fifth_done}, 32'd0);
        chk("fifth_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fifth_queued", sb_q.size(), 32'd4);
        ready_mode = 1;
        for (int n = 0; n < 50 && !fifth_done; n++) @(negedge clk);
        chk("fifth_accepted", {31'd0, fifth_done}, 32'd1);
        drain();

        // Reset with three buffered words
        ready_mode = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(2, i, 0, 0, i + 4, i + 8, 13'(i * 40));
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_count", {16'd0, instr_count}, 32'd0);
        chk("midrst_out_instr", out_instr, 32'd0);
        sb_q.delete();
        exp_count = 16'd0;
        held = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("no_stale_word", {31'd0, out_valid}, 32'd0);

        // Randomized traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 127),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 13'($urandom_range(0, 8191)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        ready_mode = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit, upstream offers a field bundle.
REQ-004 SHALL have port in_ready, output, 1 bit, encoder can accept the bundle this cycle.
REQ-005 SHALL have port op_class, input, 2 bits, 00 R-type, 01 load, 10 store, 11 branch.
REQ-006 SHALL have ports funct3 (input, 3 bits) and funct7 (input, 7 bits), instruction function fields.
REQ-007 SHALL have ports rd, rs1 and rs2, each input, 5 bits, register indices.
REQ-008 SHALL have port imm, input, 13 bits, signed immediate/offset in two's complement.
REQ-009 SHALL have port out_valid, output, 1 bit, out_instr holds a valid word.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream consumes the word.
REQ-011 SHALL have port out_instr, output, 32 bits, encoded RV32I instruction word.
REQ-012 SHALL have port out_err, output, 1 bit, error tag that travels with out_instr.
REQ-013 SHALL have port instr_count, output, 16 bits, count of words consumed downstream.

Function
REQ-014 SHALL accept a bundle when in_valid and in_ready are both 1 on a clock edge ("push").
REQ-015 SHALL consume a word when out_valid and out_ready are both 1 on a clock edge ("pop").
REQ-016 SHALL encode opcode 0110011 for R, 0000011 for load, 0100011 for store and 1100011 for branch.
REQ-017 SHALL encode R-type as funct7|rs2|rs1|funct3|rd|opcode, and load as imm[11:0]|rs1|funct3|rd|opcode.
REQ-018 SHALL encode store as imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode, and branch as imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-019 SHALL ignore fields unused by a format (for example funct7 on load, rd on store and branch).
REQ-020 SHALL encode at push time and store each word plus its err tag in a 4-entry FIFO.
REQ-021 SHALL present the FIFO head on out_instr/out_err with out_valid = (occupancy != 0).
REQ-022 SHALL give push-to-out_valid latency of 1 cycle when the FIFO is empty; there is no combinational in-to-out path.
REQ-023 SHALL drive in_ready = (occupancy < 4) as a registered signal, independent of out_ready.
REQ-024 SHALL, on a simultaneous push and pop, perform both and leave occupancy unchanged.
REQ-025 SHALL ignore a pop attempt when the FIFO is empty and a push attempt when it is full.
REQ-026 SHALL wrap the read and write pointers modulo 4.
REQ-027 SHALL hold out_instr and out_err stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment instr_count on every pop and wrap 0xFFFF -> 0x0000.

Reset
REQ-029 SHALL, while reset_n=0, force out_valid=0, in_ready=0, out_instr=0, out_err=0, instr_count=0, pointers=0 and occupancy=0.
REQ-030 SHALL raise in_ready to 1 on the first clock edge after reset_n deasserts.
REQ-031 SHALL, when reset is asserted mid-operation, discard all buffered words without popping them.

Configuration
REQ-032 SHALL, when macro ENC_IMM_CHECK_EN is defined, set err=1 for a load or store whose imm is outside -2048..2047, and for a branch whose imm[0]=1.
REQ-033 SHALL, with ENC_IMM_CHECK_EN defined, still push and pop an err=1 word normally, encoding the truncated field.
REQ-034 SHALL, without ENC_IMM_CHECK_EN, tie out_err to 0 and silently truncate immediates to format width.

Verification
REQ-035 SHALL cover: R-type funct7=0, rs2=2, rs1=1, funct3=0, rd=3 with out_ready=1 -> out_instr=0x002081B3 one cycle later, instr_count=1.
REQ-036 SHALL cover: load rd=5, rs1=2, funct3=2, imm=8 -> 0x00812283; then store rs2=5, rs1=2, funct3=2, imm=12 -> 0x00512623.
REQ-037 SHALL cover: branch rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3, out_err=0.
REQ-038 SHALL cover: out_ready=0 with 5 pushes offered -> in_ready=0 after the 4th push; the 5th bundle is held until 1 pop; pop order matches push order.
REQ-039 SHALL cover: ENC_IMM_CHECK_EN defined, load imm=4095 -> out_err=1; branch imm=3 -> out_err=1; with the macro undefined -> out_err=0.
REQ-040 SHALL cover: reset_n pulsed low with 3 words buffered -> out_valid=0 immediately, instr_count=0, no stale word after release.
